udp_cmd_rx_parser: RTL and testbench

- Sits directly downstream of the UDP receive port (app_rx_* stream), alongside the LED display consumer.
- Frames each received UDP payload and validates it as a 3-byte key command: FF 8E 7E (key3 command) or 00 FF 66 (key4 command).
- Emits a one-cycle decoded command strobe plus a sticky last-command register.
- Keeps saturating good and bad packet counters for debug LEDs.

---
 rtl/udp_cmd_rx_parser.sv | 141 ++++++++++++++
 tb/tb_udp_cmd_rx_parser.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/udp_cmd_rx_parser.sv
// Frames UDP receive payloads and decodes 3-byte key commands into a one-cycle strobe,
// a sticky last-command register and saturating good/bad packet counters.
module udp_cmd_rx_parser #(
    parameter int          CMD_LEN       = 3,
    parameter logic [23:0] CMD_A_PATTERN = 24'hFF8E7E,
    parameter logic [23:0] CMD_B_PATTERN = 24'h00FF66,
    parameter int          CNT_W         = 16
) (
    input  logic             udp_rx_clk,
    input  logic             reset,
    input  logic             app_rx_data_valid,
    input  logic [7:0]       app_rx_data,
    input  logic [15:0]      app_rx_data_length,
    output logic             cmd_valid,
    output logic [1:0]       cmd_code,
    output logic [23:0]      last_cmd,
    output logic [CNT_W-1:0] pkt_ok_cnt,
    output logic [CNT_W-1:0] pkt_err_cnt
);

    localparam int BC_W = $clog2(CMD_LEN + 1);

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_RECV,
        S_DROP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [23:0]       cap_q, cap_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [1:0]        cmd_code_q, cmd_code_d;
    logic [23:0]       last_cmd_q, last_cmd_d;
    logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        cap_d       = cap_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        last_cmd_d  = last_cmd_q;
        ok_cnt_d    = ok_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            S_RESYNC: begin
                if (!app_rx_data_valid) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (app_rx_data_valid) begin
                    if (app_rx_data_length == 16'(CMD_LEN)) begin
                        cap_d      = {cap_q[15:0], app_rx_data};
                        byte_cnt_d = BC_W'(1);
                        state_d    = S_RECV;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_RECV: begin
                if (app_rx_data_valid) begin
                    if (byte_cnt_q < BC_W'(CMD_LEN)) begin
                        cap_d      = {cap_q[15:0], app_rx_data};
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (byte_cnt_q == BC_W'(CMD_LEN)) begin
                    state_d = S_DONE;
                end else begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = S_IDLE;
                end
            end
            S_DROP: begin
                if (!app_rx_data_valid) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = S_IDLE;
                end
            end
            S_DONE: begin
                if (cap_q == CMD_A_PATTERN) begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = 2'b01;
                    last_cmd_d  = cap_q;
                    ok_cnt_d    = sat_inc(ok_cnt_q);
                end else if (cap_q == CMD_B_PATTERN) begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = 2'b10;
                    last_cmd_d  = cap_q;
                    ok_cnt_d    = sat_inc(ok_cnt_q);
                end else begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end
                // A packet starting in the gap cycle cannot be framed; swallow it uncounted.
                state_d = app_rx_data_valid ? S_RESYNC : S_IDLE;
            end
            default: state_d = S_RESYNC;
        endcase
    end

    always_ff @(posedge udp_rx_clk) begin
        if (reset) begin
            state_q     <= S_RESYNC;
            byte_cnt_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 2'b00;
            last_cmd_q  <= 24'h0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            last_cmd_q  <= last_cmd_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_ff @(posedge udp_rx_clk) begin
        cap_q <= cap_d;
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign last_cmd    = last_cmd_q;
    assign pkt_ok_cnt  = ok_cnt_q;
    assign pkt_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_udp_cmd_rx_parser.sv
// Directed bench for udp_cmd_rx_parser: a full-width instance plus a 2-bit-counter
// instance sharing the same stimulus so counter saturation is reachable quickly.
module tb_udp_cmd_rx_parser;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [7:0]  data;
    logic [15:0] length;

    logic        cmd_valid,  s_cmd_valid;
    logic [1:0]  cmd_code,   s_cmd_code;
    logic [23:0] last_cmd,   s_last_cmd;
    logic [15:0] ok_cnt,     err_cnt;
    logic [1:0]  s_ok_cnt,   s_err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt  = 0;
    int spulse_cnt = 0;
    logic [1:0] codes [0:31];

    udp_cmd_rx_parser #(.CNT_W(16)) dut (
        .udp_rx_clk        (clk),
        .reset             (reset),
        .app_rx_data_valid (valid),
        .app_rx_data       (data),
        .app_rx_data_length(length),
        .cmd_valid         (cmd_valid),
        .cmd_code          (cmd_code),
        .last_cmd          (last_cmd),
        .pkt_ok_cnt        (ok_cnt),
        .pkt_err_cnt       (err_cnt)
    );

    udp_cmd_rx_parser #(.CNT_W(2)) dut_s (
        .udp_rx_clk        (clk),
        .reset             (reset),
        .app_rx_data_valid (valid),
        .app_rx_data       (data),
        .app_rx_data_length(length),
        .cmd_valid         (s_cmd_valid),
        .cmd_code          (s_cmd_code),
        .last_cmd          (s_last_cmd),
        .pkt_ok_cnt        (s_ok_cnt),
        .pkt_err_cnt       (s_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cmd_valid) begin
            codes[pulse_cnt[4:0]] = cmd_code;
            pulse_cnt++;
        end
        if (s_cmd_valid) spulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends n bytes (byte0 in bits 39:32) followed by gap cycles of valid=0.
    task automatic send_pkt(input logic [39:0] bytes, input int n, input logic [15:0] len,
                            input int gap);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid  = 1'b1;
            data   = bytes[39-8*i -: 8];
            length = len;
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (gap - 1) @(posedge clk);
        if (gap > 1) #1;
    endtask

    initial begin
        reset  = 1'b1;
        valid  = 1'b0;
        data   = 8'h00;
        length = 16'd0;
        idle(3);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code",  32'(cmd_code),  32'd0);
        check("rst_last_cmd",  32'(last_cmd),  32'd0);
        check("rst_ok_cnt",    32'(ok_cnt),    32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        reset = 1'b0;
        idle(3);

        // Command A with exact latency: valid=0 sampled at N+1, pulse N+2..N+3.
        send_pkt(40'hFF8E7E0000, 3, 16'd3, 1);
        idle(1);
        check("lat_n1_low",  32'(cmd_valid), 32'd0);
        idle(1);
        check("lat_n2_high", 32'(cmd_valid), 32'd1);
        check("a_code",      32'(cmd_code),  32'd1);
        check("a_last",      32'(last_cmd),  32'hFF8E7E);
        check("a_ok",        32'(ok_cnt),    32'd1);
        check("a_err",       32'(err_cnt),   32'd0);
        idle(1);
        check("lat_n3_low",  32'(cmd_valid), 32'd0);
        idle(3);

        // Back-to-back B then A with the minimum framable gap.
        send_pkt(40'h00FF660000, 3, 16'd3, 2);
        send_pkt(40'hFF8E7E0000, 3, 16'd3, 4);
        idle(2);
        check("b2b_pulses", 32'(pulse_cnt), 32'd3);
        check("b2b_code1",  32'(codes[1]),  32'd2);
        check("b2b_code2",  32'(codes[2]),  32'd1);
        check("b2b_ok",     32'(ok_cnt),    32'd3);

        // Packet starting in the DONE cycle is discarded uncounted.
        send_pkt(40'h00FF660000, 3, 16'd3, 1);
        send_pkt(40'hFF8E7E0000, 3, 16'd3, 4);
        idle(2);
        check("coll_pulses", 32'(pulse_cnt), 32'd4);
        check("coll_code",   32'(cmd_code),  32'd2);
        check("coll_last",   32'(last_cmd),  32'h00FF66);
        check("coll_ok",     32'(ok_cnt),    32'd4);
        check("coll_err",    32'(err_cnt),   32'd0);

        // Malformed packets.
        send_pkt(40'h0102030400, 4, 16'd4, 4);
        check("len4_err",   32'(err_cnt), 32'd1);
        send_pkt(40'hFF8E000000, 2, 16'd3, 4);
        check("short_err",  32'(err_cnt), 32'd2);
        send_pkt(40'hFF8E7E00FF, 5, 16'd3, 4);
        idle(2);
        check("long_err",    32'(err_cnt),   32'd3);
        check("long_code",   32'(cmd_code),  32'd2);
        check("long_last",   32'(last_cmd),  32'h00FF66);
        check("mal_ok",      32'(ok_cnt),    32'd4);
        check("mal_pulses",  32'(pulse_cnt), 32'd4);

        // Unknown pattern.
        send_pkt(40'hABCDEF0000, 3, 16'd3, 4);
        idle(2);
        check("unk_err",    32'(err_cnt),   32'd4);
        check("unk_code",   32'(cmd_code),  32'd2);
        check("unk_pulses", 32'(pulse_cnt), 32'd4);

        // Reset after byte1, released while the packet is still streaming.
        @(posedge clk); #1; valid = 1'b1; data = 8'hFF; length = 16'd3;
        @(posedge clk); #1; data = 8'h8E;
        @(posedge clk); #1; data = 8'h7E; reset = 1'b1;
        @(posedge clk); #1; data = 8'h11; reset = 1'b0;
        check("mid_rst_code", 32'(cmd_code), 32'd0);
        @(posedge clk); #1; valid = 1'b0; data = 8'h00;
        idle(4);
        check("mid_cmd_valid", 32'(cmd_valid), 32'd0);
        check("mid_last",      32'(last_cmd),  32'd0);
        check("mid_ok",        32'(ok_cnt),    32'd0);
        check("mid_err",       32'(err_cnt),   32'd0);
        check("mid_pulses",    32'(pulse_cnt), 32'd4);
        send_pkt(40'hFF8E7E0000, 3, 16'd3, 4);
        idle(2);
        check("post_rst_ok",     32'(ok_cnt),    32'd1);
        check("post_rst_code",   32'(cmd_code),  32'd1);
        check("post_rst_pulses", 32'(pulse_cnt), 32'd5);
        check("sat_pre",         32'(s_ok_cnt),  32'd1);

        // Saturation: the 2-bit instance tops out at 3 but still pulses.
        send_pkt(40'hFF8E7E0000, 3, 16'd3, 4);
        send_pkt(40'h00FF660000, 3, 16'd3, 4);
        send_pkt(40'hFF8E7E0000, 3, 16'd3, 4);
        idle(2);
        check("sat_ok",      32'(s_ok_cnt),   32'd3);
        check("sat_pulses",  32'(spulse_cnt), 32'd8);
        check("sat_err",     32'(s_err_cnt),  32'd0);
        check("full_ok",     32'(ok_cnt),     32'd4);
        check("full_pulses", 32'(pulse_cnt),  32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
